// File: rtl/serial_sum_deserializer.sv
// rtl/serial_sum_deserializer.sv - reassembles LSB-first serial sum bits into a WIDTH-bit word plus carry
module serial_sum_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_bit,
    input  logic             s_valid,
    input  logic             s_first,
    input  logic             s_carry,
    output logic [WIDTH-1:0] m_data,
    output logic             m_carry,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_carry_q, m_carry_d;
    logic             m_valid_q, m_valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;

    logic complete, restart, stray, overrun, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            m_data_q    <= '0;
            m_carry_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            m_data_q    <= m_data_d;
            m_carry_q   <= m_carry_d;
            m_valid_q   <= m_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // s_first always (re)starts a frame; in SHIFT that abandons the partial one.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        complete = 1'b0;
        restart  = 1'b0;
        stray    = 1'b0;
        if (s_valid) begin
            case (state_q)
                IDLE: begin
                    if (s_first) begin
                        shift_d    = '0;
                        shift_d[0] = s_bit;
                        cnt_d      = CW'(1);
                        state_d    = SHIFT;
                    end else begin
                        stray = 1'b1;
                    end
                end
                SHIFT: begin
                    if (s_first) begin
                        restart    = 1'b1;
                        shift_d    = '0;
                        shift_d[0] = s_bit;
                        cnt_d      = CW'(1);
                    end else if (cnt_q == LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        for (int i = 0; i < WIDTH - 1; i++) begin
                            if (cnt_q == CW'(i)) shift_d[i] = s_bit;
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Single-entry output slot; a completion may refill it on the consuming edge.
    always_comb begin
        accept      = m_valid_q && m_ready;
        overrun     = complete && m_valid_q && !m_ready;
        m_data_d    = m_data_q;
        m_carry_d   = m_carry_q;
        m_valid_d   = m_valid_q;
        if (accept) m_valid_d = 1'b0;
        if (complete && !overrun) begin
            m_data_d  = {s_bit, shift_q};
            m_carry_d = s_carry;
            m_valid_d = 1'b1;
        end
        busy_d      = (state_d == SHIFT);
        frame_err_d = stray || restart || overrun;
    end

    assign m_data    = m_data_q;
    assign m_carry   = m_carry_q;
    assign m_valid   = m_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
endmodule
